// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges stage stall requests and sequences mispredict flush/redirect/refill
module pipe_stall_ctrl #(
  parameter int REFILL_CYC = 1,
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             mem_stall_req,
  input  logic             ex_pre_fail,
  input  logic [31:0]      ex_target,
  output logic [5:0]       stall_stmt,
  output logic             flush_o,
  output logic             pc_redirect_o,
  output logic [31:0]      pc_target_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             hang_o
);
  typedef enum logic [1:0] {IDLE, REDIR, REFILL} state_t;
  localparam int RW = $clog2(REFILL_CYC + 2);
  state_t           state_q, state_d;
  logic [RW-1:0]    refill_q, refill_d;
  logic [15:0]      wd_q, wd_d;
  logic [31:0]      target_q, target_d;
  logic [CNT_W-1:0] scnt_q, scnt_d, fcnt_q, fcnt_d;
  logic             hang_q, hang_d, redir_q;
  logic [5:0]       base, stall;
  logic             accept, stalled;
  // Stall encoding, mispredict sequencing and counter/watchdog next-state
  always_comb begin
    base = mem_stall_req ? 6'b011111 : id_stall_req ? 6'b000111 :
           if_stall_req ? 6'b000011 : 6'b000000;
    stall = state_q == REDIR ? (mem_stall_req ? 6'b011111 : 6'b000000)
                             : base | {3'b000, state_q == REFILL, 2'b00};
    accept = ex_pre_fail && !mem_stall_req && state_q != REDIR;
    stalled = stall != 6'b000000;
    state_d = state_q;
    refill_d = refill_q;
    target_d = target_q;
    fcnt_d = fcnt_q;
    if (accept) begin
      state_d = REDIR;
      target_d = ex_target;
      fcnt_d = fcnt_q != '1 ? fcnt_q + 1'b1 : fcnt_q;
    end else if (state_q == REDIR && !mem_stall_req) begin
      state_d = REFILL_CYC > 0 ? REFILL : IDLE;
      refill_d = RW'(REFILL_CYC);
    end else if (state_q == REFILL && !mem_stall_req) begin
      refill_d = refill_q - 1'b1;
      state_d = refill_q == RW'(1) ? IDLE : REFILL;
    end
    scnt_d = stalled && scnt_q != '1 ? scnt_q + 1'b1 : scnt_q;
    wd_d = !stalled ? 16'd0 : wd_q != '1 ? wd_q + 1'b1 : wd_q;
    hang_d = hang_q || (stalled && int'(wd_q) + 1 >= WDOG_LIMIT);
  end
  // Reset dominates; rdy low stops every stage and suppresses the flush
  always_comb begin
    stall_stmt = !rst ? 6'b000000 : !rdy ? 6'b111111 : stall;
    flush_o = rst && rdy && (accept || state_q == REDIR);
  end
  // State, redirect strobe, target, counters and watchdog; all frozen while rdy is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      refill_q <= '0;
      wd_q <= '0;
      target_q <= '0;
      scnt_q <= '0;
      fcnt_q <= '0;
      hang_q <= 1'b0;
      redir_q <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      refill_q <= refill_d;
      wd_q <= wd_d;
      target_q <= target_d;
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
      hang_q <= hang_d;
      redir_q <= state_d == REDIR;
    end
  end
  assign pc_redirect_o = redir_q;
  assign pc_target_o = target_q;
  assign stall_cnt_o = scnt_q;
  assign flush_cnt_o = fcnt_q;
  assign hang_o = hang_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: scoreboard bench with a behavioural model of the stall sequencer
module tb_pipe_stall_ctrl;
  localparam int RC = 2;
  localparam int WL = 8;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic if_s = 1'b0, id_s = 1'b0, mem_s = 1'b0, pf = 1'b0;
  logic [31:0] tgt = '0;
  logic [5:0] stall_stmt;
  logic flush_o, pc_redirect_o, hang_o;
  logic [31:0] pc_target_o, stall_cnt_o, flush_cnt_o;
  int tests = 0, fails = 0;
  typedef struct {
    logic [5:0] st;
    logic fl, rd, hg;
    logic [31:0] tg, sc, fc;
  } exp_t;
  exp_t q[$];
  bit m_redir, m_hang;
  int m_bub, m_run;
  logic [31:0] m_tgt;
  longint m_sc, m_fc;
  pipe_stall_ctrl #(.REFILL_CYC(RC), .WDOG_LIMIT(WL), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_stall_req(if_s), .id_stall_req(id_s),
    .mem_stall_req(mem_s), .ex_pre_fail(pf), .ex_target(tgt), .stall_stmt(stall_stmt),
    .flush_o(flush_o), .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .hang_o(hang_o));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Monitor: every clocked cycle presents a full output set; compare against the oldest expectation
  always @(negedge clk) begin
    #3;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_stmt", 32'(stall_stmt), 32'(e.st));
      chk("flush_o", 32'(flush_o), 32'(e.fl));
      chk("pc_redirect_o", 32'(pc_redirect_o), 32'(e.rd));
      chk("pc_target_o", pc_target_o, e.tg);
      chk("stall_cnt_o", stall_cnt_o, e.sc);
      chk("flush_cnt_o", flush_cnt_o, e.fc);
      chk("hang_o", 32'(hang_o), 32'(e.hg));
    end
  end
  task automatic model_reset();
    m_redir = 0; m_hang = 0; m_bub = 0; m_run = 0; m_tgt = '0; m_sc = 0; m_fc = 0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall_stmt), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_redir", 32'(pc_redirect_o), 32'd0);
    chk("rst_target", pc_target_o, 32'd0);
    chk("rst_cnts", stall_cnt_o | flush_cnt_o, 32'd0);
    chk("rst_hang", 32'(hang_o), 32'd0);
    model_reset();
    {if_s, id_s, mem_s, pf, rdy} = 5'b00001;
    tgt = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  // One clock of stimulus: drive inputs, predict this cycle's outputs, then advance the model past the edge
  task automatic cyc(input logic m, input logic i, input logic f, input logic p,
                     input logic [31:0] t, input logic r);
    exp_t e;
    logic [5:0] base;
    bit acc;
    @(negedge clk);
    mem_s = m; id_s = i; if_s = f; pf = p; tgt = t; rdy = r;
    #2;
    e.rd = m_redir; e.tg = m_tgt; e.sc = 32'(m_sc); e.fc = 32'(m_fc); e.hg = m_hang;
    if (!r) begin
      e.st = 6'h3F; e.fl = 0;
      q.push_back(e);
    end else begin
      base = m ? 6'h1F : i ? 6'h07 : f ? 6'h03 : 6'h00;
      acc = 0;
      if (m_redir) begin
        e.st = m ? 6'h1F : 6'h00; e.fl = 1;
      end else begin
        e.st = base | (m_bub > 0 ? 6'h04 : 6'h00);
        acc = p && !m; e.fl = acc;
      end
      q.push_back(e);
      if (e.st != 0) begin
        if (m_sc < 64'hFFFF_FFFF) m_sc++;
        m_run++;
        if (m_run >= WL) m_hang = 1;
      end else m_run = 0;
      if (m_redir) begin
        if (!m) begin m_redir = 0; m_bub = RC; end
      end else if (acc) begin
        m_redir = 1; m_bub = 0; m_tgt = t;
        if (m_fc < 64'hFFFF_FFFF) m_fc++;
      end else if (m_bub > 0 && !m) m_bub--;
    end
  endtask
  initial begin
    do_reset();
    cyc(0,0,0,0,0,1);
    // stall priority, dropped one per cycle
    cyc(1,1,1,0,0,1); cyc(0,1,1,0,0,1); cyc(0,0,1,0,0,1); cyc(0,0,0,0,0,1);
    // mispredict to 0x1040 with two refill bubbles
    cyc(0,0,0,1,32'h0000_1040,1);
    for (int k = 0; k < 4; k++) cyc(0,0,0,0,0,1);
    // mispredict deferred behind a mem stall for 3 cycles
    for (int k = 0; k < 3; k++) cyc(1,0,0,1,32'h0000_2000,1);
    cyc(0,0,0,1,32'h0000_2000,1);
    for (int k = 0; k < 4; k++) cyc(0,0,0,0,0,1);
    // rdy low for 5 cycles in the middle of refill
    cyc(0,0,0,1,32'h0000_3000,1); cyc(0,0,0,0,0,1); cyc(0,0,0,0,0,1);
    for (int k = 0; k < 5; k++) cyc(0,1,0,0,0,0);
    for (int k = 0; k < 3; k++) cyc(0,0,0,0,0,1);
    // 7 stalled cycles then a gap must not trip the watchdog
    for (int k = 0; k < 7; k++) cyc(0,1,0,0,0,1);
    for (int k = 0; k < 2; k++) cyc(0,0,0,0,0,1);
    // randomized traffic
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0,4) == 0, $urandom_range(0,3) == 0, $urandom_range(0,3) == 0,
          $urandom_range(0,5) == 0, $urandom, $urandom_range(0,7) != 0);
    for (int k = 0; k < 4; k++) cyc(0,0,0,0,0,1);
    // asynchronous reset while in the redirect cycle
    cyc(0,0,0,1,32'h0000_4000,1);
    @(negedge clk);
    #4;
    chk("pre_rst_redir", 32'(pc_redirect_o), 32'(m_redir));
    do_reset();
    cyc(0,0,0,0,0,1);
    // 8 stalled cycles trip the watchdog, which stays set afterwards
    for (int k = 0; k < 8; k++) cyc(0,1,0,0,0,1);
    for (int k = 0; k < 3; k++) cyc(0,0,0,0,0,1);
    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core.
- Merges stage stall requests into the shared `stall_stmt` bus consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Sequences branch-mispredict recovery: flush, then a registered PC redirect, then a refill bubble window.
- Keeps stall/flush performance counters and a stall-hang watchdog.

Parameters:
- REFILL_CYC, 1, bubble cycles injected into id_ex after a redirect; 0 skips the REFILL state.
- WDOG_LIMIT, 1024, consecutive stalled cycles before `hang_o` sets; 16-bit range.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low freezes the block
- if_stall_req  in  1  fetch/icache miss
- id_stall_req  in  1  load-use hazard
- mem_stall_req  in  1  memory controller busy
- ex_pre_fail  in  1  branch mispredict detected in EX
- ex_target  in  32  correct target PC from EX
- stall_stmt  out  6  [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = Stop
- flush_o  out  1  kill if_id and id_ex contents
- pc_redirect_o  out  1  one-cycle PC load strobe
- pc_target_o  out  32  redirect PC
- stall_cnt_o  out  CNT_W  cycles with any stall_stmt bit set (rdy high)
- flush_cnt_o  out  CNT_W  accepted mispredicts
- hang_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst low, async): state=IDLE, `stall_stmt`=0, `flush_o`=0, `pc_redirect_o`=0, `pc_target_o`=0, both counters=0, `hang_o`=0, watchdog count=0, refill count=0.
- Base stall encoding is combinational, with strict priority:
  - mem_stall_req → 6'b011111
  - else id_stall_req → 6'b000111
  - else if_stall_req → 6'b000011
  - else 6'b000000
- rdy low: `stall_stmt`=6'b111111; `flush_o`=0; `pc_redirect_o` holds its registered value; all state, counters and watchdog frozen.
- FSM states: IDLE, REDIR, REFILL.
- IDLE:
  - A mispredict is accepted when ex_pre_fail=1 and mem_stall_req=0.
  - On accept: `flush_o`=1 combinationally that cycle; `pc_target_o`<=ex_target; flush_cnt++; next state REDIR.
  - ex_pre_fail while mem_stall_req=1 is not accepted. EX is held, so the request persists and is accepted on the first cycle mem_stall_req=0.
- REDIR (exactly 1 cycle):
  - `pc_redirect_o`=1 and `flush_o`=1, killing the wrong-path fetch.
  - id_stall_req and if_stall_req are ignored; only the mem stall encoding applies.
  - Next state: REFILL if REFILL_CYC>0, else IDLE.
  - If mem_stall_req=1, stay in REDIR with `pc_redirect_o` held until it clears.
- REFILL:
  - `stall_stmt`[2] is forced to 1 (OR-ed into the base encoding), so id_ex receives bubbles while fetch restarts.
  - The refill counter decrements only on cycles with no mem stall; exit to IDLE when it reaches 0.
  - ex_pre_fail=1 in REFILL is treated as a fresh accept: `flush_o`=1, reload target, flush_cnt++, go to REDIR.
- `pc_redirect_o` is registered and equals 1 only in REDIR; `pc_target_o` is stable from the accept edge until the next accept.
- Counters:
  - Saturate at all-ones; no wrap.
  - stall_cnt increments on cycles with rdy=1 and `stall_stmt`≠0.
- Watchdog:
  - Counts consecutive rdy=1 cycles with `stall_stmt`≠0.
  - Clears on any rdy=1 cycle with `stall_stmt`=0.
  - At WDOG_LIMIT, `hang_o` sets and stays set until reset.
- Simultaneous requests: mem_stall_req together with ex_pre_fail gives mem priority, and the flush is deferred as in IDLE.

Test Plan:
1. Reset mid-REDIR: assert rst low asynchronously → all outputs 0 and state IDLE without waiting for a clock edge; release → `stall_stmt`=0.
2. Stall priority: mem, id and if requests raised together, then dropped one per cycle → `stall_stmt` 011111, 000111, 000011, 000000; stall_cnt=3.
3. Mispredict with REFILL_CYC=2 and ex_target=0x0000_1040:
   - `flush_o`=1 at cycle 0.
   - At cycle 1, `pc_redirect_o`=1, `pc_target_o`=0x1040 and `flush_o`=1.
   - Cycles 2–3 give `stall_stmt`=000100.
   - IDLE at cycle 4, flush_cnt=1.
4. ex_pre_fail with mem_stall_req=1 for 3 cycles → `flush_o`=0 for those 3 cycles, then `flush_o`=1 on the 4th; flush_cnt increments once.
5. rdy=0 during REFILL for 5 cycles → `stall_stmt`=111111 and the refill count is unchanged; the remaining bubbles resume after rdy=1.
6. Watchdog with WDOG_LIMIT=8: hold id_stall_req for 8 cycles → `hang_o`=1 after the 8th edge and still 1 after stalls clear. With only 7 stalled cycles followed by a gap → `hang_o`=0.
